// File: rtl/parity_serial_checker_if.sv
// Serial parity link, receive side: framed bit stream in, checked byte and status out.
interface parity_serial_checker_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              sof;
  logic              bit_in;
  logic              bit_valid;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  // Upstream side: drives the serial stream and the counter clear.
  modport master (
    output sof, bit_in, bit_valid, err_clr,
    input  data_out, data_valid, parity_err, busy, err_count
  );

  // Checker side.
  modport slave (
    input  sof, bit_in, bit_valid, err_clr,
    output data_out, data_valid, parity_err, busy, err_count
  );
endinterface

// File: rtl/parity_serial_checker.sv
// Deserializes DATA_W data bits (MSB first) plus one parity bit, checks parity,
// and presents the byte with an error flag and a saturating error count.
module parity_serial_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  parity_serial_checker_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  state_t             r_state, w_next;
  logic [DATA_W-1:0]  r_shift;
  logic [CW-1:0]      r_cnt;
  logic               r_par;
  logic [DATA_W-1:0]  r_data;
  logic               r_dv;
  logic               r_perr;
  logic [CNT_W-1:0]   r_errcnt;

  logic w_odd, w_start, w_shift, w_done, w_perr;

  // A valid sof restarts the frame from any state, so it takes priority over shift/done.
  assign w_odd   = (ODD != 0);
  assign w_start = bus.bit_valid & bus.sof;
  assign w_shift = bus.bit_valid & ~bus.sof & (r_state == S_DATA);
  assign w_done  = bus.bit_valid & ~bus.sof & (r_state == S_PARITY);
  // r_par is the running XOR of the data bits, so mismatch = bit ^ parity ^ ODD.
  assign w_perr  = bus.bit_in ^ r_par ^ w_odd;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; bit_valid low never moves the FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_DATA;
      S_DATA: begin
        if (w_start)                                w_next = S_DATA;
        else if (bus.bit_valid && r_cnt == LAST_BIT) w_next = S_PARITY;
      end
      S_PARITY: begin
        if (w_start)            w_next = S_DATA;
        else if (bus.bit_valid) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Shift register, bit counter and running parity for the frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else if (w_start) begin
      r_shift <= {{(DATA_W-1){1'b0}}, bus.bit_in};
      r_cnt   <= CW'(1);
      r_par   <= bus.bit_in;
    end else if (w_shift) begin
      r_shift <= {r_shift[DATA_W-2:0], bus.bit_in};
      r_cnt   <= r_cnt + CW'(1);
      r_par   <= r_par ^ bus.bit_in;
    end else if (w_done) begin
      r_cnt   <= '0;
    end
  end

  // Result registers: data/flag hold until the next completed frame, valid pulses once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_perr <= 1'b0;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= w_done;
      if (w_done) begin
        r_data <= r_shift;
        r_perr <= w_perr;
      end
    end
  end

  // Saturating error counter; a clear beats a coincident erroring completion.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                      r_errcnt <= '0;
    else if (bus.err_clr)                           r_errcnt <= '0;
    else if (w_done && w_perr && r_errcnt != CNT_MAX) r_errcnt <= r_errcnt + CNT_W'(1);
  end

  // Output drive; busy is simply "not idle".
  always_comb begin
    bus.busy       = (r_state != S_IDLE);
    bus.data_out   = r_data;
    bus.data_valid = r_dv;
    bus.parity_err = r_perr;
    bus.err_count  = r_errcnt;
  end
endmodule
